// File: rtl/row_window_3tap.sv
// row_window_3tap
//   Streams binarised pixels in row-major order and produces a 3-pixel horizontal
//   window (left, centre, right) for every pixel. Neighbours outside the row are
//   zero-padded. The window feeds a downstream 3-input OR used for horizontal dilation.
//
// Ports
//   clk        in   rising-edge clock
//   resetN     in   asynchronous active-low reset
//   pixelIn    in   binary pixel
//   pixelValid in   pixelIn valid
//   pixelReady out  block accepts a pixel this cycle
//   winLeft    out  pixel at column c-1 (0 at column 0)
//   winCenter  out  pixel at column c
//   winRight   out  pixel at column c+1 (0 at the last column)
//   winCol     out  centre column c
//   winValid   out  window outputs valid
//   winReady   in   downstream accepts the window
//   rowEnd     out  window is the last of its row
//   frameEnd   out  window is the last of its frame
module row_window_3tap #(
  parameter int unsigned ROW_WIDTH = 28,
  parameter int unsigned ROW_COUNT = 28,
  parameter int unsigned COL_W     = 5,
  parameter int unsigned ROW_W     = 5
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             pixelIn,
  input  logic             pixelValid,
  output logic             pixelReady,
  output logic             winLeft,
  output logic             winCenter,
  output logic             winRight,
  output logic [COL_W-1:0] winCol,
  output logic             winValid,
  input  logic             winReady,
  output logic             rowEnd,
  output logic             frameEnd
);

  localparam logic [COL_W-1:0] LastCol = COL_W'(ROW_WIDTH - 1);
  localparam logic [ROW_W-1:0] LastRow = ROW_W'(ROW_COUNT - 1);

  // StEmpty: waiting for column 0. StHold: mid-row, cur/prev hold the last two pixels.
  // StFlush: row complete, the last column's window still has to be emitted.
  typedef enum logic [1:0] {StEmpty, StHold, StFlush} stateE;

  stateE            stateQ, stateD;
  logic             prevQ, prevD;
  logic             curQ, curD;
  logic [COL_W-1:0] colQ, colD;
  logic [ROW_W-1:0] rowCntQ, rowCntD;

  logic             leftQ, leftD;
  logic             centerQ, centerD;
  logic             rightQ, rightD;
  logic [COL_W-1:0] winColQ, winColD;
  logic             validQ, validD;
  logic             rowEndQ, rowEndD;
  logic             frameEndQ, frameEndD;

  logic slotFree;
  logic readyInt;
  logic accept;

  // The output register can take a new window if it is empty or being drained now.
  always_comb begin
    slotFree = !validQ || winReady;
    readyInt = 1'b0;
    case (stateQ)
      StEmpty: readyInt = 1'b1;
      StHold:  readyInt = slotFree;
      StFlush: readyInt = 1'b0;
      default: readyInt = 1'b0;
    endcase
    accept = pixelValid && readyInt;
  end

  always_comb begin
    stateD    = stateQ;
    prevD     = prevQ;
    curD      = curQ;
    colD      = colQ;
    rowCntD   = rowCntQ;
    leftD     = leftQ;
    centerD   = centerQ;
    rightD    = rightQ;
    winColD   = winColQ;
    rowEndD   = rowEndQ;
    frameEndD = frameEndQ;
    validD    = validQ;

    // A consumed window drops valid unless a new one overwrites it below.
    if (validQ && winReady) begin
      validD = 1'b0;
    end

    case (stateQ)
      StEmpty: begin
        if (accept) begin
          prevD  = 1'b0;
          curD   = pixelIn;
          colD   = COL_W'(1);
          stateD = StHold;
        end
      end
      StHold: begin
        if (accept) begin
          leftD     = prevQ;
          centerD   = curQ;
          rightD    = pixelIn;
          winColD   = colQ - COL_W'(1);
          rowEndD   = 1'b0;
          frameEndD = 1'b0;
          validD    = 1'b1;
          prevD     = curQ;
          curD      = pixelIn;
          colD      = colQ + COL_W'(1);
          if (colQ == LastCol) begin
            stateD = StFlush;
          end
        end
      end
      StFlush: begin
        if (slotFree) begin
          leftD     = prevQ;
          centerD   = curQ;
          rightD    = 1'b0;
          winColD   = LastCol;
          rowEndD   = 1'b1;
          frameEndD = (rowCntQ == LastRow);
          validD    = 1'b1;
          colD      = '0;
          rowCntD   = (rowCntQ == LastRow) ? '0 : rowCntQ + ROW_W'(1);
          stateD    = StEmpty;
        end
      end
      default: begin
        stateD = StEmpty;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stateQ    <= StEmpty;
      prevQ     <= 1'b0;
      curQ      <= 1'b0;
      colQ      <= '0;
      rowCntQ   <= '0;
      leftQ     <= 1'b0;
      centerQ   <= 1'b0;
      rightQ    <= 1'b0;
      winColQ   <= '0;
      validQ    <= 1'b0;
      rowEndQ   <= 1'b0;
      frameEndQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      prevQ     <= prevD;
      curQ      <= curD;
      colQ      <= colD;
      rowCntQ   <= rowCntD;
      leftQ     <= leftD;
      centerQ   <= centerD;
      rightQ    <= rightD;
      winColQ   <= winColD;
      validQ    <= validD;
      rowEndQ   <= rowEndD;
      frameEndQ <= frameEndD;
    end
  end

  assign pixelReady = readyInt;
  assign winLeft    = leftQ;
  assign winCenter  = centerQ;
  assign winRight   = rightQ;
  assign winCol     = winColQ;
  assign winValid   = validQ;
  assign rowEnd     = rowEndQ;
  assign frameEnd   = frameEndQ;

endmodule
